// File: rtl/edge_frame_writer.sv
// edge_frame_writer: turns the aligned edge-pixel stream into linear frame-buffer writes with geometry checks
module edge_frame_writer #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fsync_in,
    input  logic              rsync_in,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              bin_mode_in,
    input  logic [PIX_W-1:0]  thresh_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [8:0]        rows_written,
    output logic              err_short_line,
    output logic              err_long_line
);
    localparam int COL_W = $clog2(COLS + 1);
    localparam logic [COL_W-1:0]  COLS_C = COL_W'(COLS);
    localparam logic [8:0]        ROWS_C = 9'(ROWS);
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(COLS);

    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [8:0]        rows_q, rows_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic              fsync_q, rsync_q, armed_q, armed_d;
    logic              fs_rise, fs_fall, line_end, pix_vld;

    always_comb begin
        // armed_q blocks a false rise when fsync is already high out of reset
        fs_rise      = fsync_in & ~fsync_q & armed_q;
        fs_fall      = ~fsync_in & fsync_q;
        line_end     = (~rsync_in & rsync_q) | (fs_fall & rsync_in);
        pix_vld      = fsync_in & rsync_in;
        armed_d      = armed_q | ~fsync_in;
        state_d      = state_q;
        col_d        = col_q;
        rows_d       = rows_q;
        base_d       = base_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;
        if (state_q == IDLE) begin
            if (fs_rise) begin
                col_d       = '0;
                rows_d      = '0;
                base_d      = '0;
                wr_addr_d   = '0;
                err_short_d = 1'b0;
                err_long_d  = 1'b0;
                state_d     = ACTIVE;
            end
        end else begin
            if (state_q == ACTIVE) begin
                if (pix_vld && col_q < COLS_C) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_W'(col_q);
                    wr_data_d = bin_mode_in ? ((pix_in >= thresh_in) ? '1 : '0) : pix_in;
                    col_d     = col_q + 1'b1;
                end else if (pix_vld) begin
                    err_long_d = 1'b1;
                end
                if (line_end) begin
                    err_short_d = err_short_q | (col_q < COLS_C);
                    col_d       = '0;
                    base_d      = base_q + STEP_C;
                    rows_d      = rows_q + 9'd1;
                    state_d     = (rows_q + 9'd1 == ROWS_C) ? FULL : ACTIVE;
                end
            end
            if (fs_fall) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            rows_q       <= '0;
            base_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            fsync_q      <= 1'b0;
            rsync_q      <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            rows_q       <= rows_d;
            base_q       <= base_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            fsync_q      <= fsync_in;
            rsync_q      <= rsync_in;
            armed_q      <= armed_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign frame_done     = frame_done_q;
    assign rows_written   = rows_q;
    assign err_short_line = err_short_q;
    assign err_long_line  = err_long_q;
endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer: directed frames against a bench-side write-stream model
module tb_edge_frame_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsync_in = 1'b0;
    logic        rsync_in = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        bin_mode_in = 1'b0;
    logic [7:0]  thresh_in = '0;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic [8:0]  rows_written;
    logic        err_short_line;
    logic        err_long_line;

    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          stream_err = 0;
    int          mark, fd0;
    logic [16:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [24:0] exp_q[$];

    edge_frame_writer dut (
        .clk(clk), .rst_n(rst_n), .fsync_in(fsync_in), .rsync_in(rsync_in),
        .pix_in(pix_in), .bin_mode_in(bin_mode_in), .thresh_in(thresh_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .rows_written(rows_written),
        .err_short_line(err_short_line), .err_long_line(err_long_line)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            if (exp_q.size() == 0) stream_err++;
            else if (exp_q.pop_front() !== {wr_addr, wr_data}) stream_err++;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic rs, input logic [7:0] p);
        fsync_in = fs;
        rsync_in = rs;
        pix_in   = p;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int row, input int col, input logic [7:0] p, input bit w);
        if (w) exp_q.push_back({17'(row * 320 + col),
                                bin_mode_in ? ((p >= thresh_in) ? 8'hFF : 8'h00) : p});
        drive(1'b1, 1'b1, p);
    endtask

    task automatic line(input int row, input int n, input bit w);
        for (int c = 0; c < n; c++) pix(row, c, 8'((c + row) & 255), w && c < 320);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic frame_start();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        mark = wr_cnt;
        fd0  = fd_cnt;
    endtask

    task automatic stream_chk(input string tag);
        chk({tag, " stream errs"}, stream_err, 0);
        chk({tag, " pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2;
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst rows", rows_written, 0);
        chk("rst err_short", err_short_line, 0);
        chk("rst err_long", err_long_line, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // full frame of raw magnitudes
        frame_start();
        pix(0, 0, 8'h00, 1);
        chk("t1 first wr_en", wr_en, 1);
        chk("t1 first addr", wr_addr, 0);
        for (int c = 1; c < 320; c++) pix(0, c, 8'(c), 1);
        drive(1'b1, 1'b0, 8'h00);
        for (int r = 1; r < 240; r++) line(r, 320, 1);
        chk("t1 done before fall", frame_done, 0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t1 frame_done", frame_done, 1);
        drive(1'b0, 1'b0, 8'h00);
        chk("t1 frame_done cleared", frame_done, 0);
        chk("t1 writes", wr_cnt - mark, 76800);
        chk("t1 last addr", last_addr, 76799);
        chk("t1 last data", last_data, (319 + 239) & 255);
        chk("t1 done count", fd_cnt - fd0, 1);
        chk("t1 rows", rows_written, 240);
        chk("t1 err_short", err_short_line, 0);
        chk("t1 err_long", err_long_line, 0);
        stream_chk("t1");

        // binarised output around the threshold
        bin_mode_in = 1'b1;
        thresh_in   = 8'd100;
        frame_start();
        chk("t2 idle wr_en", wr_en, 0);
        pix(0, 0, 8'd99, 1);
        chk("t2 p0 wr_en", wr_en, 1);
        chk("t2 p0 addr", wr_addr, 0);
        chk("t2 p0 data", wr_data, 8'h00);
        pix(0, 1, 8'd100, 1);
        chk("t2 p1 addr", wr_addr, 1);
        chk("t2 p1 data", wr_data, 8'hFF);
        pix(0, 2, 8'd101, 1);
        chk("t2 p2 addr", wr_addr, 2);
        chk("t2 p2 data", wr_data, 8'hFF);
        drive(1'b1, 1'b0, 8'h00);
        chk("t2 blank wr_en", wr_en, 0);
        chk("t2 hold data", wr_data, 8'hFF);
        chk("t2 hold addr", wr_addr, 2);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        stream_chk("t2");
        bin_mode_in = 1'b0;

        // short line in row 5
        frame_start();
        chk("t3 errs cleared", err_short_line, 0);
        for (int r = 0; r < 5; r++) line(r, 320, 1);
        chk("t3 short before", err_short_line, 0);
        line(5, 319, 1);
        chk("t3 short set", err_short_line, 1);
        chk("t3 long clear", err_long_line, 0);
        pix(6, 0, 8'h06, 1);
        chk("t3 row6 addr", wr_addr, 1920);
        drive(1'b1, 1'b0, 8'h00);
        chk("t3 rows", rows_written, 7);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        stream_chk("t3");

        // long line in row 0
        frame_start();
        chk("t4 short cleared", err_short_line, 0);
        line(0, 322, 1);
        chk("t4 long set", err_long_line, 1);
        chk("t4 short clear", err_short_line, 0);
        chk("t4 row0 writes", wr_cnt - mark, 320);
        pix(1, 0, 8'h01, 1);
        chk("t4 row1 addr", wr_addr, 320);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        stream_chk("t4");

        // excess lines after ROWS are ignored, including their overlength
        frame_start();
        chk("t5 long cleared", err_long_line, 0);
        for (int r = 0; r < 240; r++) line(r, 2, 1);
        line(240, 322, 0);
        line(241, 322, 0);
        chk("t5 writes", wr_cnt - mark, 480);
        chk("t5 rows", rows_written, 240);
        chk("t5 long ignored", err_long_line, 0);
        chk("t5 short", err_short_line, 1);
        chk("t5 done before fall", frame_done, 0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t5 frame_done", frame_done, 1);
        drive(1'b0, 1'b0, 8'h00);
        chk("t5 frame_done cleared", frame_done, 0);
        chk("t5 done count", fd_cnt - fd0, 1);
        stream_chk("t5");

        // asynchronous reset mid-frame with fsync held high
        frame_start();
        for (int r = 0; r < 100; r++) line(r, 2, 1);
        line(100, 330, 1);
        pix(100, 0, 8'h64, 0);
        rst_n = 1'b0;
        #1;
        chk("t6 rst wr_en", wr_en, 0);
        chk("t6 rst rows", rows_written, 0);
        chk("t6 rst long", err_long_line, 0);
        chk("t6 rst addr", wr_addr, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h11);
        rst_n = 1'b1;
        mark = wr_cnt;
        fd0  = fd_cnt;
        for (int c = 0; c < 5; c++) pix(0, c, 8'h22, 0);
        drive(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) pix(0, c, 8'h33, 0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t6 no done", frame_done, 0);
        drive(1'b0, 1'b0, 8'h00);
        chk("t6 no writes", wr_cnt - mark, 0);
        chk("t6 no done count", fd_cnt - fd0, 0);
        frame_start();
        chk("t6 rows cleared", rows_written, 0);
        chk("t6 short cleared", err_short_line, 0);
        pix(0, 0, 8'h44, 1);
        chk("t6 first addr", wr_addr, 0);
        chk("t6 first data", wr_data, 8'h44);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("t6 frame_done", frame_done, 1);
        drive(1'b0, 1'b0, 8'h00);
        stream_chk("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
